uart_tx_ctrl: RTL and testbench
===============================

// Module: uart_tx_ctrl
// PURPOSE
//  Transmit-side sequencer for the UART. Accepts bytes over a valid/ready handshake and
//  serialises them onto txd as start/data/parity/stop frames. Bit timing is paced by the
//  oversampled baud enable from the baud rate generator. Frame format comes from
//  APB-programmed config and is latched per frame.
// PARAMETERS
//  OVERSAMPLE  16  baud_tick pulses per bit period; must be >= 2
//  DATA_W      8   width of tx_data; the maximum number of data bits
// PORTS
//  uart_ref_clk    in   1       block clock; all logic is posedge
//  rst_n           in   1       asynchronous, active-low reset
//  baud_tick       in   1       1-cycle enable at OVERSAMPLE x bit rate, synchronous to uart_ref_clk
//  tx_data         in   DATA_W  byte to send; bits above the configured length are ignored
//  tx_valid        in   1       tx_data is valid
//  tx_ready        out  1       high only in IDLE; a transfer happens when tx_valid && tx_ready
//  cfg_data_bits   in   2       data length: 00=5, 01=6, 10=7, 11=8
//  cfg_parity_en   in   1       1 = insert a parity bit
//  cfg_parity_odd  in   1       1 = odd parity, 0 = even parity
//  cfg_stop2       in   1       1 = two stop bits, 0 = one stop bit
//  txd             out  1       serial output; idles high
//  tx_busy         out  1       high in every state except IDLE
//  frame_done      out  1       1-cycle pulse when the last stop bit completes
// BEHAVIOUR
//  - Reset (async, rst_n low): txd=1, tx_ready=1, tx_busy=0, frame_done=0, state=IDLE,
//    counters=0. A reset mid-frame aborts the frame and drives txd to 1 immediately.
//  - All outputs are registered. The clock is uart_ref_clk; the reset is rst_n.
//  - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//  - On the accept cycle, latch tx_data, all cfg_* inputs and the parity bit; clear tick_cnt and
//    bit_cnt. The next cycle is START: txd=0, tx_ready=0, tx_busy=1.
//  - tick_cnt ($clog2(OVERSAMPLE) bits) increments only on baud_tick. On the baud_tick where
//    tick_cnt==OVERSAMPLE-1, the current bit ends and tick_cnt wraps to 0.
//  - Each bit lasts exactly OVERSAMPLE baud_ticks, however many cycles lie between ticks.
//  - DATA sends bits LSB first. It leaves after bit (len-1), where len = 5 + cfg_data_bits.
//  - Parity is the XOR of the len latched bits, inverted when odd parity is selected.
//    PARITY is skipped when cfg_parity_en=0.
//  - STOP drives txd=1 for 1 bit, or 2 bits when cfg_stop2=1.
//  - Leaving STOP: the FSM enters IDLE and frame_done=1 for that one cycle. tx_ready is high in
//    the same cycle, so a held tx_valid is accepted in that cycle.
//  - Config and tx_data changes mid-frame have no effect. tx_valid is ignored while tx_ready=0.
//  - baud_tick is ignored in IDLE. A baud_tick on the accept cycle is not counted.
// CONFIGURATION
//  UART_TX_BREAK_EN defined: adds input port break_req (1 bit).
//    - break_req high in IDLE forces txd=0 and tx_ready=0; a transfer is never accepted then.
//    - break_req asserted mid-frame waits until frame_done, then the break starts.
//    - On deassert, txd=1 and the block holds for OVERSAMPLE baud_ticks (the mark-after-break)
//      before tx_ready rises.
//  UART_TX_BREAK_EN undefined: no break_req port; txd is always 1 in IDLE.
// TESTING  (OVERSAMPLE=16, baud_tick=1 every cycle unless stated)
//  1. Reset: assert rst_n low mid-run -> txd=1, tx_ready=1, tx_busy=0, frame_done=0 with no clock edge.
//  2. tx_data=0xA5, 8N1 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 16 cycles;
//     frame_done 160 cycles after START begins.
//  3. tx_data=0x3C, 7 data bits, even parity, 2 stop -> data 0,0,1,1,1,1,0, parity=0;
//     frame is 11 bits = 176 cycles.
//  4. baud_tick every 3rd cycle, 0x01 8N1 -> each bit = 48 cycles; the start bit is low for exactly 48 cycles.
//  5. tx_valid held high with 0x55 then 0xAA -> second accept in the frame_done cycle;
//     second start bit one cycle later; no idle bit between frames.
//  6. Pulse rst_n low during data bit 3 -> txd=1 at once.
//     After release, a new 0x0F frame is clean; changing cfg mid-frame leaves the frame unchanged.
//  7. (UART_TX_BREAK_EN) break_req high for 100 cycles in IDLE -> txd=0 for 100 cycles,
//     tx_ready=0; after release, txd=1 and tx_ready rises 16 ticks later.

Source files
------------

// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: serialises bytes into start/data/parity/stop frames paced by baud_tick.
// Break generation (break_req port) is compiled in only when UART_TX_BREAK_EN is defined.
module uart_tx_ctrl #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_W     = 8
) (
   input  logic              uart_ref_clk,
   input  logic              rst_n,
   input  logic              baud_tick,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   input  logic [1:0]        cfg_data_bits,
   input  logic              cfg_parity_en,
   input  logic              cfg_parity_odd,
   input  logic              cfg_stop2,
`ifdef UART_TX_BREAK_EN
   input  logic              break_req,
`endif
   output logic              txd,
   output logic              tx_busy,
   output logic              frame_done
);

   localparam int TICK_W = $clog2(OVERSAMPLE);
   localparam int BIT_W  = 3;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK, S_MAB
   } state_t;

   state_t            state, state_n;
   logic [TICK_W-1:0] tick_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [BIT_W-1:0]  last_idx;
   logic [DATA_W-1:0] data_sh;
   logic [DATA_W-1:0] data_masked;
   logic              par_bit, par_en, stop2, par_calc;
   logic              bit_end, accept, brk;
   logic              txd_n, ready_n, busy_n, done_n;

`ifdef UART_TX_BREAK_EN
   assign brk = break_req;
`else
   assign brk = 1'b0;
`endif

   assign bit_end = baud_tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
   assign accept  = (state == S_IDLE) && tx_valid && tx_ready && !brk;

   // Parity covers only the configured data length; higher bits of tx_data are ignored.
   always_comb begin
      data_masked = '0;
      for (int i = 0; i < DATA_W; i++) begin
         if (i < 5 + int'(cfg_data_bits)) data_masked[i] = tx_data[i];
      end
      par_calc = (^data_masked) ^ cfg_parity_odd;
   end

   // Next-state logic also produces the next value of every registered output.
   always_comb begin
      state_n = state;
      txd_n   = txd;
      ready_n = tx_ready;
      busy_n  = tx_busy;
      done_n  = 1'b0;
      case (state)
         S_IDLE: begin
            txd_n   = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
            if (brk) begin
               state_n = S_BREAK;
               txd_n   = 1'b0;
               ready_n = 1'b0;
               busy_n  = 1'b1;
            end else if (accept) begin
               state_n = S_START;
               txd_n   = 1'b0;
               ready_n = 1'b0;
               busy_n  = 1'b1;
            end
         end
         S_START: begin
            if (bit_end) begin
               state_n = S_DATA;
               txd_n   = data_sh[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               if (bit_cnt != last_idx) begin
                  txd_n = data_sh[1];
               end else if (par_en) begin
                  state_n = S_PARITY;
                  txd_n   = par_bit;
               end else begin
                  state_n = S_STOP;
                  txd_n   = 1'b1;
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_n = S_STOP;
               txd_n   = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end && !(stop2 && bit_cnt == '0)) begin
               done_n = 1'b1;
               if (brk) begin
                  state_n = S_BREAK;
                  txd_n   = 1'b0;
               end else begin
                  state_n = S_IDLE;
                  txd_n   = 1'b1;
                  ready_n = 1'b1;
                  busy_n  = 1'b0;
               end
            end
         end
         S_BREAK: begin
            txd_n = 1'b0;
            if (!brk) begin
               state_n = S_MAB;
               txd_n   = 1'b1;
            end
         end
         S_MAB: begin
            if (bit_end) begin
               state_n = S_IDLE;
               ready_n = 1'b1;
               busy_n  = 1'b0;
            end
         end
         default: begin
            state_n = S_IDLE;
            txd_n   = 1'b1;
            ready_n = 1'b1;
            busy_n  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge uart_ref_clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         txd        <= 1'b1;
         tx_ready   <= 1'b1;
         tx_busy    <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_n;
         txd        <= txd_n;
         tx_ready   <= ready_n;
         tx_busy    <= busy_n;
         frame_done <= done_n;
         // Ticks seen in IDLE, on the accept cycle, or during a break never count toward a bit.
         if (state == S_IDLE || state == S_BREAK || bit_end) begin
            tick_cnt <= '0;
         end else if (baud_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
         end
         if (state_n != state) begin
            bit_cnt <= '0;
         end else if (bit_end && (state == S_DATA || state == S_STOP)) begin
            bit_cnt <= bit_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge uart_ref_clk) begin
      if (accept) begin
         data_sh  <= tx_data;
         last_idx <= BIT_W'(4) + BIT_W'(cfg_data_bits);
         par_bit  <= par_calc;
         par_en   <= cfg_parity_en;
         stop2    <= cfg_stop2;
      end else if (state == S_DATA && bit_end) begin
         data_sh  <= data_sh >> 1;
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: expected txd bit streams are queued at send time
// and popped while the serial output is observed.
module tb_uart_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       baud_tick;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic [1:0] cfg_data_bits;
   logic       cfg_parity_en;
   logic       cfg_parity_odd;
   logic       cfg_stop2;
   logic       txd;
   logic       tx_busy;
   logic       frame_done;
`ifdef UART_TX_BREAK_EN
   logic       break_req;
`endif

   int   checks   = 0;
   int   failures = 0;
   int   tick_div = 1;
   logic bit_q[$];
   int   len_q[$];

   uart_tx_ctrl #(.OVERSAMPLE(16), .DATA_W(8)) dut (
      .uart_ref_clk  (clk),
      .rst_n         (rst_n),
      .baud_tick     (baud_tick),
      .tx_data       (tx_data),
      .tx_valid      (tx_valid),
      .tx_ready      (tx_ready),
      .cfg_data_bits (cfg_data_bits),
      .cfg_parity_en (cfg_parity_en),
      .cfg_parity_odd(cfg_parity_odd),
      .cfg_stop2     (cfg_stop2),
`ifdef UART_TX_BREAK_EN
      .break_req     (break_req),
`endif
      .txd           (txd),
      .tx_busy       (tx_busy),
      .frame_done    (frame_done)
   );

   initial forever #5 clk = ~clk;

   // baud_tick changes just after the rising edge, so it is stable when read at the falling edge.
   initial begin
      int cnt;
      cnt       = 0;
      baud_tick = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         cnt       = (cnt + 1 >= tick_div) ? 0 : cnt + 1;
         baud_tick = (cnt == 0);
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_frame(input logic [7:0] d, input logic [1:0] db, input logic pe,
                             input logic po, input logic s2);
      int   n;
      logic p;
      n = 5 + int'(db);
      p = po;
      bit_q.push_back(1'b0);
      for (int i = 0; i < n; i++) begin
         bit_q.push_back(d[i]);
         p = p ^ d[i];
      end
      if (pe) bit_q.push_back(p);
      bit_q.push_back(1'b1);
      if (s2) bit_q.push_back(1'b1);
      len_q.push_back(n + 2 + int'(pe) + int'(s2));
   endtask

   // Called at a falling edge; leaves tx_valid high when hold is set.
   task automatic send(input logic [7:0] d, input logic [1:0] db, input logic pe,
                       input logic po, input logic s2, input bit align, input bit hold);
      int n;
      n = 0;
      while (!(tx_ready === 1'b1 && (!align || baud_tick === 1'b1)) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("accept_wait", 32'(n < 2000), 32'd1);
      tx_data        = d;
      cfg_data_bits  = db;
      cfg_parity_en  = pe;
      cfg_parity_odd = po;
      cfg_stop2      = s2;
      tx_valid       = 1'b1;
      push_frame(d, db, pe, po, s2);
      @(negedge clk);
      if (!hold) tx_valid = 1'b0;
   endtask

   // Starts at the first falling edge of the start bit; ends at the frame_done cycle.
   task automatic check_frame(input int cyc, input string tag);
      int   n;
      logic e;
      n = len_q.pop_front();
      chk({tag, "_busy"}, tx_busy, 1);
      chk({tag, "_rdy_lo"}, tx_ready, 0);
      for (int i = 0; i < n; i++) begin
         e = bit_q.pop_front();
         chk($sformatf("%s_bit%0d_first", tag, i), txd, e);
         repeat (cyc - 1) @(negedge clk);
         chk($sformatf("%s_bit%0d_last", tag, i), txd, e);
         if (i == n - 1) chk({tag, "_done_early"}, frame_done, 0);
         @(negedge clk);
      end
      chk({tag, "_done"}, frame_done, 1);
      chk({tag, "_rdy_end"}, tx_ready, 1);
      chk({tag, "_busy_end"}, tx_busy, 0);
      chk({tag, "_txd_idle"}, txd, 1);
   endtask

   initial begin
      rst_n          = 1'b0;
      tx_valid       = 1'b0;
      tx_data        = 8'h00;
      cfg_data_bits  = 2'b11;
      cfg_parity_en  = 1'b0;
      cfg_parity_odd = 1'b0;
      cfg_stop2      = 1'b0;
`ifdef UART_TX_BREAK_EN
      break_req      = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_txd", txd, 1);
      chk("rst_rdy", tx_ready, 1);
      chk("rst_busy", tx_busy, 0);
      chk("rst_done", frame_done, 0);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_frame(16, "a5_8n1");

      send(8'h3C, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check_frame(16, "3c_7e2");

      send(8'hF3, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_frame(16, "f3_5o1");

      tick_div = 3;
      send(8'h01, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_frame(48, "01_div3");
      tick_div = 1;

      send(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tx_data = 8'hAA;
      push_frame(8'hAA, 2'b11, 1'b0, 1'b0, 1'b0);
      check_frame(16, "55_b2b");
      @(negedge clk);
      tx_valid = 1'b0;
      check_frame(16, "aa_b2b");

      send(8'h00, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (70) @(negedge clk);
      chk("abort_pre_txd", txd, 0);
      chk("abort_pre_busy", tx_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("abort_txd", txd, 1);
      chk("abort_rdy", tx_ready, 1);
      chk("abort_busy", tx_busy, 0);
      chk("abort_done", frame_done, 0);
      bit_q.delete();
      len_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      send(8'h0F, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cfg_data_bits  = 2'b00;
      cfg_parity_en  = 1'b1;
      cfg_parity_odd = 1'b1;
      cfg_stop2      = 1'b1;
      tx_data        = 8'hFF;
      check_frame(16, "0f_cfgchg");

`ifdef UART_TX_BREAK_EN
      break_req = 1'b1;
      tx_valid  = 1'b1;
      tx_data   = 8'h00;
      @(negedge clk);
      chk("brk_txd_first", txd, 0);
      chk("brk_rdy", tx_ready, 0);
      repeat (99) @(negedge clk);
      chk("brk_txd_last", txd, 0);
      break_req = 1'b0;
      tx_valid  = 1'b0;
      @(negedge clk);
      chk("mab_txd", txd, 1);
      chk("mab_rdy_first", tx_ready, 0);
      repeat (15) @(negedge clk);
      chk("mab_rdy_last", tx_ready, 0);
      @(negedge clk);
      chk("mab_rdy_up", tx_ready, 1);
      chk("mab_txd_idle", txd, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
